// File: rtl/jpeg_in_fifo.sv
// jpeg_in_fifo
// Input buffer between the PCI target FIFO register path and the JPEG
// decoder core. Host words are stored in a synchronous-read RAM and handed
// to the decoder through a single output register that forms a
// first-word-fall-through valid/ready interface. The RAM and the output
// register together hold exactly DEPTH = 2**AW words.
//
// Ports:
//   rst          async reset, active-low
//   clk          clock
//   flush        sync clear, active-high (PCI-side jpeg_reset bit)
//   fifo_we      write strobe, one word per cycle
//   fifo_wd      write data (32 bit)
//   fifo_full    registered: level == DEPTH (or flush held); writes dropped
//   fifo_almfull registered: level >= DEPTH - AF_MARGIN (or flush held)
//   dout_valid   dout_data holds the oldest word
//   dout_data    oldest word, byte-reversed when BSWAP = 1
//   dout_ready   consumer takes the word when dout_valid & dout_ready
//   level        accepted words not yet consumed (0..DEPTH)
//   overflow     sticky, set by a write while full; cleared by flush
module jpeg_in_fifo #(
  parameter int AW        = 9,
  parameter int AF_MARGIN = 16,
  parameter bit BSWAP     = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          fifo_we,
  input  logic [31:0]   fifo_wd,
  output logic          fifo_full,
  output logic          fifo_almfull,
  output logic          dout_valid,
  output logic [31:0]   dout_data,
  input  logic          dout_ready,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL  = (AW+1)'(DEPTH - AF_MARGIN);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          push;
  logic          pop;
  logic          load;
  logic [AW:0]   level_next;

  function automatic logic [31:0] byte_order(input logic [31:0] w);
    if (BSWAP)
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
    else
      return w;
  endfunction

  // fifo_full is the registered status, so a write while full is dropped
  // even if the same edge pops a word.
  assign push = fifo_we & ~fifo_full & ~flush;
  assign pop  = dout_valid & dout_ready & ~flush;

  // Refill the output register from RAM whenever it is empty or being
  // consumed. ram_cnt only counts words written at earlier edges, so the
  // read never races the write of the same edge.
  assign load = (ram_cnt != '0) & (~dout_valid | pop) & ~flush;

  assign level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // RAM write port; kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= fifo_wd;
  end

  // Pointers, counters, output register and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      level        <= '0;
      dout_valid   <= 1'b0;
      dout_data    <= '0;
      fifo_full    <= 1'b0;
      fifo_almfull <= 1'b0;
      overflow     <= 1'b0;
    end else if (flush) begin
      // Held flush reports no space so the host stops writing;
      // dout_data keeps its last value.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      level        <= '0;
      dout_valid   <= 1'b0;
      fifo_full    <= 1'b1;
      fifo_almfull <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr     <= rd_ptr + 1'b1;
        dout_data  <= byte_order(mem[rd_ptr]);
        dout_valid <= 1'b1;
      end else if (pop) begin
        dout_valid <= 1'b0;
      end
      ram_cnt      <= ram_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
      level        <= level_next;
      fifo_full    <= (level_next == DEPTH_L);
      fifo_almfull <= (level_next >= AF_LVL);
      if (fifo_we & fifo_full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: doc/jpeg_in_fifo.md
Name: jpeg_in_fifo

Overview:
Input buffer between the PCI target interface and the JPEG decoder core. Accepts 32-bit compressed-stream words written by the host through the PCI FIFO register path (fifo_we/fifo_wd). Returns full/almost-full status to the PCI side for host polling. Presents words to the decoder core on a first-word-fall-through valid/ready interface. Cleared synchronously by the JPEG soft-reset control bit.

Parameters:
AW, 9, address width; capacity DEPTH = 2^AW words (512)
AF_MARGIN, 16, fifo_almfull asserts when level >= DEPTH - AF_MARGIN
BSWAP, 1, 1 = byte-reverse each word on output (dout_data = {wd[7:0],wd[15:8],wd[23:16],wd[31:24]}); 0 = pass through

Ports:
rst  input  1  asynchronous reset, active-low
clk  input  1  clock
flush  input  1  synchronous clear, active-high; driven by the PCI-side jpeg_reset bit
fifo_we  input  1  write strobe from PCI interface, one word per cycle
fifo_wd  input  32  write data
fifo_full  output  1  no space; writes are dropped
fifo_almfull  output  1  level >= DEPTH - AF_MARGIN
dout_valid  output  1  dout_data holds the oldest word
dout_data  output  32  oldest word (byte-swapped per BSWAP)
dout_ready  input  1  decoder core consumes the word when dout_valid & dout_ready
level  output  AW+1  accepted words not yet consumed (0..DEPTH)
overflow  output  1  sticky; a write arrived while full

Behaviour:
- Reset (rst low, async): pointers = 0, level = 0, dout_valid = 0, dout_data = 0, fifo_full = 0, fifo_almfull = 0, overflow = 0.
- Accept: write accepted at an edge iff fifo_we = 1, fifo_full = 0, flush = 0.
  - fifo_full is evaluated before any same-cycle pop, so a write while full is dropped even if dout_ready pops that cycle.
  - A dropped write sets overflow. Data is lost and level is unchanged.
- Storage: DEPTH-entry synchronous-read RAM plus one output register. Capacity counts both, so total capacity is exactly DEPTH words.
- Latency: a word accepted at edge k into an empty FIFO gives dout_valid = 1 after edge k+1, with dout_data = that word.
- Pop: occurs at an edge when dout_valid & dout_ready.
  - If more words are stored, the next word is on dout_data after the same edge, with dout_valid held at 1. Back-to-back pops give one word per clock.
  - If no words are stored, dout_valid drops after the pop edge.
  - dout_data and dout_valid must not change while dout_valid = 1 and dout_ready = 0.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH with no gap at the wrap.
- level arithmetic: level_next = level + push - pop, where push/pop are the accepted-write and pop events of the same edge.
  - Simultaneous push and pop leaves level unchanged.
  - level never exceeds DEPTH and never underflows.
- Status outputs are registered and reflect level after each edge:
  - fifo_full = (level == DEPTH)
  - fifo_almfull = (level >= DEPTH - AF_MARGIN)
- flush = 1 at an edge:
  - level = 0, pointers = 0, dout_valid = 0, overflow = 0.
  - Any write or pop in that cycle is ignored and does not set overflow.
  - While flush is held, fifo_full = 1 and fifo_almfull = 1, so the host sees no space.
  - Both drop on the first edge after flush deasserts.
  - Flush mid-stream discards all words.
- dout_data when dout_valid = 0 is don't-care for the consumer. The implementation holds the last value.

Test Plan:
- Reset then single word: write 0x11223344, BSWAP=1 -> dout_valid rises two edges after write strobe, dout_data = 0x44332211, level = 1; pop with dout_ready -> dout_valid = 0, level = 0.
- Fill: DEPTH=512, dout_ready = 0, write 0..511 -> fifo_almfull first = 1 after word 496 accepted (level 496); fifo_full = 1 after word 512 (level 512). Write 0xDEAD -> dropped, overflow = 1, level = 512.
- Full-throughput streaming with wrap: 2000 sequential words written every cycle, dout_ready = 1 -> output sequence identical, no gaps after first word, level <= 2, overflow = 0.
- Simultaneous push/pop at full: level = 512, fifo_we = 1 and pop same cycle -> write dropped, overflow = 1, level = 511; next cycle write accepted -> level = 512.
- Backpressure stability: random dout_ready toggling (~50%) with random writes -> dout_data stable while valid & !ready; scoreboard matches in order.
- Flush mid-operation: level = 100, overflow = 1, assert flush 3 cycles with fifo_we = 1 -> fifo_full = fifo_almfull = 1 during flush, then level = 0, dout_valid = 0, overflow = 0. Next written word 0xA5A5A5A5 emerges first.
